sad_min_select: RTL and testbench

- Consumer end of the SAD processing-element interface in the full-search block-matching datapath.
- Accepts the PE's SAD result stream, one candidate per cycle after the PE pipeline latency.
- Aligns each result with the candidate position it belongs to and tracks the running minimum SAD.
- At the end of the search window, reports the best motion vector and its SAD.

---
 rtl/sad_min_select.sv | 169 ++++++++++++++++
 tb/tb_sad_min_select.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_min_select.sv
// rtl/sad_min_select.sv - SAD result consumer: aligns PE sums to candidate positions, tracks minimum, reports best MV (optional SAD_EARLY_EXIT_EN)
module sad_min_select #(
  parameter int SAD_W  = 12,
  parameter int SRCH_W = 13,
  parameter int MV_W   = 4,
  parameter int PE_LAT = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cand_valid,
  input  logic [SAD_W-1:0]  sad_in,
`ifdef SAD_EARLY_EXIT_EN
  input  logic [SAD_W-1:0]  sad_thresh,
  output logic              early,
`endif
  output logic              pe_en,
  output logic              busy,
  output logic              done,
  output logic [MV_W-1:0]   mv_x,
  output logic [MV_W-1:0]   mv_y,
  output logic [SAD_W-1:0]  best_sad
);

  localparam int N_CAND = SRCH_W * SRCH_W;
  localparam int PW     = (SRCH_W > 1) ? $clog2(SRCH_W) : 1;
  localparam int CW     = $clog2(N_CAND + 1);
  localparam int HALF   = (SRCH_W - 1) / 2;

  typedef enum logic [1:0] {IDLE, SEARCH, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      px, py;
  logic [PW-1:0]      best_px, best_py;
  logic [CW-1:0]      cnt;
  logic [SAD_W-1:0]   min_sad;
  logic [PE_LAT-1:0]  vpipe;

  logic               accept;
  logic               aligned;
  logic               better;
  logic               last_pos;
  logic               finish;
  logic               early_hit;
  logic               upd;
  logic               done_nxt;
  logic [PW-1:0]      fin_px, fin_py;
  logic [SAD_W-1:0]   fin_sad;

  // Candidate acceptance, SAD alignment and the best result as it stands after this cycle
  always_comb begin
    accept    = (state == SEARCH) && cand_valid && !start && (cnt < CW'(N_CAND));
    aligned   = (state != IDLE) && vpipe[PE_LAT-1] && !start;
    better    = aligned && (sad_in < min_sad);
    last_pos  = (px == PW'(SRCH_W - 1)) && (py == PW'(SRCH_W - 1));
    finish    = aligned && last_pos;
`ifdef SAD_EARLY_EXIT_EN
    early_hit = aligned && (sad_thresh != '0) && (sad_in < sad_thresh);
`else
    early_hit = 1'b0;
`endif
    upd       = better || early_hit;
    fin_px    = upd ? px : best_px;
    fin_py    = upd ? py : best_py;
    fin_sad   = upd ? sad_in : min_sad;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and status outputs; start restarts from any state
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done_nxt  = 1'b0;
    if (start) begin
      state_nxt = SEARCH;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        SEARCH: begin
          if (early_hit) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else if (accept && (cnt == CW'(N_CAND - 1))) begin
            state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          if (early_hit || finish) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign pe_en = busy;

  // Position tracking, valid pipe and running minimum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px      <= '0;
      py      <= '0;
      best_px <= '0;
      best_py <= '0;
      cnt     <= '0;
      min_sad <= '1;
      vpipe   <= '0;
    end else if (start) begin
      px      <= '0;
      py      <= '0;
      best_px <= '0;
      best_py <= '0;
      cnt     <= '0;
      min_sad <= '1;
      vpipe   <= '0;
    end else begin
      if (early_hit)
        vpipe <= '0;
      else if (busy)
        vpipe <= (vpipe << 1) | PE_LAT'(accept);
      if (accept)
        cnt <= cnt + CW'(1);
      if (aligned) begin
        if (upd) begin
          min_sad <= sad_in;
          best_px <= px;
          best_py <= py;
        end
        if (px == PW'(SRCH_W - 1)) begin
          px <= '0;
          py <= py + PW'(1);
        end else begin
          px <= px + PW'(1);
        end
      end
    end
  end

  // Reported result registers, loaded only when the search completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      mv_x     <= '0;
      mv_y     <= '0;
      best_sad <= '1;
`ifdef SAD_EARLY_EXIT_EN
      early    <= 1'b0;
`endif
    end else begin
      done <= done_nxt;
`ifdef SAD_EARLY_EXIT_EN
      early <= done_nxt && early_hit;
`endif
      if (done_nxt) begin
        mv_x     <= MV_W'(int'(fin_px) - HALF);
        mv_y     <= MV_W'(int'(fin_py) - HALF);
        best_sad <= fin_sad;
      end
    end
  end

endmodule

// File: tb/tb_sad_min_select.sv
// tb/tb_sad_min_select.sv - directed self-checking bench for sad_min_select
module tb_sad_min_select;

  localparam int SAD_W  = 12;
  localparam int SRCH_W = 13;
  localparam int MV_W   = 4;
  localparam int PE_LAT = 5;
  localparam int NC     = SRCH_W * SRCH_W;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              cand_valid;
  logic [SAD_W-1:0]  sad_in;
  logic              pe_en;
  logic              busy;
  logic              done;
  logic [MV_W-1:0]   mv_x;
  logic [MV_W-1:0]   mv_y;
  logic [SAD_W-1:0]  best_sad;
`ifdef SAD_EARLY_EXIT_EN
  logic [SAD_W-1:0]  sad_thresh;
  logic              early;
`endif

  sad_min_select #(.SAD_W(SAD_W), .SRCH_W(SRCH_W), .MV_W(MV_W), .PE_LAT(PE_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cand_valid (cand_valid),
    .sad_in     (sad_in),
`ifdef SAD_EARLY_EXIT_EN
    .sad_thresh (sad_thresh),
    .early      (early),
`endif
    .pe_en      (pe_en),
    .busy       (busy),
    .done       (done),
    .mv_x       (mv_x),
    .mv_y       (mv_y),
    .best_sad   (best_sad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int              cyc = 0;
  int              tb_cnt = 0;
  bit              tb_srch = 1'b0;
  int              cand_at [0:4095];
  logic [SAD_W-1:0] tbl [0:NC-1];
  int              done_cnt = 0;
  int              done_edge = -1;
  int              last_acc_edge = -1;
  int              s_edge = 0;
  logic [MV_W-1:0] cap_x, cap_y;
  logic [SAD_W-1:0] cap_sad;
  logic            cap_busy, cap_early;
  logic            busy_mid, pe_en_mid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [SAD_W-1:0] v);
    for (int i = 0; i < NC; i++) tbl[i] = v;
  endtask

  // One clock cycle: drive inputs, model the PE output, observe after the edge
  task automatic cycle(input logic s, input logic cv);
    int ci;
    ci = -1;
    start = s;
    cand_valid = cv;
    if (cyc >= PE_LAT && cand_at[cyc-PE_LAT] >= 0) sad_in = tbl[cand_at[cyc-PE_LAT]];
    else sad_in = '0;
    if (s) begin
      tb_cnt  = 0;
      tb_srch = 1'b1;
    end else if (cv && tb_srch) begin
      ci = tb_cnt;
      tb_cnt++;
      if (tb_cnt == NC) begin
        tb_srch = 1'b0;
        last_acc_edge = cyc;
      end
    end
    cand_at[cyc] = ci;
    @(posedge clk);
    @(negedge clk);
    if (done) begin
      done_cnt++;
      done_edge = cyc;
      cap_x     = mv_x;
      cap_y     = mv_y;
      cap_sad   = best_sad;
      cap_busy  = busy;
`ifdef SAD_EARLY_EXIT_EN
      cap_early = early;
`else
      cap_early = 1'b0;
`endif
    end
    cyc++;
  endtask

  task automatic run_search(input bit tog);
    int n;
    int d0;
    bit ph;
    d0 = done_cnt;
    s_edge = cyc;
    cycle(1'b1, 1'b0);
    busy_mid  = busy;
    pe_en_mid = pe_en;
    ph = 1'b1;
    n = 0;
    while (tb_srch && n < 1000) begin
      cycle(1'b0, tog ? ph : 1'b1);
      ph = ~ph;
      n++;
    end
    n = 0;
    while (done_cnt == d0 && n < 40) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    chk("search_done_seen", done_cnt, d0 + 1);
  endtask

  initial begin
    int d;
    int n;
    for (int i = 0; i < 4096; i++) cand_at[i] = -1;
    rst_n = 1'b0;
    start = 1'b0;
    cand_valid = 1'b0;
    sad_in = '0;
`ifdef SAD_EARLY_EXIT_EN
    sad_thresh = '0;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_pe_en", pe_en, 0);
    chk("rst_done", done, 0);
    chk("rst_mv_x", mv_x, 0);
    chk("rst_mv_y", mv_y, 0);
    chk("rst_best_sad", best_sad, 12'hFFF);
    rst_n = 1'b1;
    @(negedge clk);

    // single minimum at (9,4)
    fill(12'd100);
    tbl[4*SRCH_W+9] = 12'd20;
    run_search(1'b0);
    chk("t1_busy_mid", busy_mid, 1);
    chk("t1_pe_en_mid", pe_en_mid, 1);
    chk("t1_latency_from_start", done_edge - s_edge, NC + PE_LAT);
    chk("t1_mv_x", cap_x, 4'h3);
    chk("t1_mv_y", cap_y, 4'hE);
    chk("t1_best_sad", cap_sad, 12'd20);
    chk("t1_busy_at_done", cap_busy, 0);
    d = done_cnt;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
    chk("t1_single_done", done_cnt, d);
    chk("t1_hold_mv_x", mv_x, 4'h3);
    chk("t1_hold_best", best_sad, 12'd20);

    // tie between (2,2) and (10,10), last position also equal
    fill(12'd50);
    tbl[2*SRCH_W+2]   = 12'd5;
    tbl[10*SRCH_W+10] = 12'd5;
    tbl[NC-1]         = 12'd5;
    run_search(1'b0);
    chk("t2_mv_x", cap_x, 4'hC);
    chk("t2_mv_y", cap_y, 4'hC);
    chk("t2_best_sad", cap_sad, 12'd5);

    // gapped cand_valid, zero SAD at centre
    fill(12'd200);
    tbl[6*SRCH_W+6] = 12'd0;
    run_search(1'b1);
    chk("t3_latency_from_last", done_edge - last_acc_edge, PE_LAT);
    chk("t3_mv_x", cap_x, 4'h0);
    chk("t3_mv_y", cap_y, 4'h0);
    chk("t3_best_sad", cap_sad, 12'd0);

    // abort after 80 candidates, then full search with best at (0,12)
    fill(12'd90);
    tbl[12*SRCH_W+0] = 12'd7;
    d = done_cnt;
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 80; i++) cycle(1'b0, 1'b1);
    chk("t4_no_done_abort", done_cnt, d);
    run_search(1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
    chk("t4_exactly_one_done", done_cnt, d + 1);
    chk("t4_mv_x", cap_x, 4'hA);
    chk("t4_mv_y", cap_y, 4'h6);
    chk("t4_best_sad", cap_sad, 12'd7);

    // asynchronous reset while draining
    d = done_cnt;
    cycle(1'b1, 1'b0);
    n = 0;
    while (tb_srch && n < 400) begin
      cycle(1'b0, 1'b1);
      n++;
    end
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    chk("t5_busy_in_drain", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_pe_en", pe_en, 0);
    chk("t5_rst_best_sad", best_sad, 12'hFFF);
    @(negedge clk);
    rst_n = 1'b1;
    tb_srch = 1'b0;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);
    chk("t5_no_done_after_rst", done_cnt, d);
    chk("t5_idle_after_rst", busy, 0);

`ifdef SAD_EARLY_EXIT_EN
    // early exit at (3,0)
    fill(12'd100);
    tbl[3] = 12'd4;
    sad_thresh = 12'd10;
    d = done_cnt;
    s_edge = cyc;
    cycle(1'b1, 1'b0);
    n = 0;
    while (done_cnt == d && n < 200) begin
      cycle(1'b0, 1'b1);
      n++;
    end
    tb_srch = 1'b0;
    chk("t6_done_seen", done_cnt, d + 1);
    chk("t6_done_edge", done_edge - s_edge, 4 + PE_LAT);
    chk("t6_early", cap_early, 1);
    chk("t6_mv_x", cap_x, 4'hD);
    chk("t6_mv_y", cap_y, 4'hA);
    chk("t6_best_sad", cap_sad, 12'd4);
    chk("t6_busy", cap_busy, 0);
    sad_thresh = '0;
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0);
    chk("t6_no_second_done", done_cnt, d + 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
